// File: rtl/boot_loader.sv
// boot_loader: receives a serial byte image, packs it little-endian into a
// word buffer while holding the CPU in reset, then releases the CPU and
// serves buffer words onto the shared data bus during the boot phase.
//
// Build option: define BOOT_CHECKSUM_EN to append an 8-bit checksum byte
// after the image. A mismatching checksum parks the loader in ERR.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   in_byte   serial-side image byte
//   in_valid  in_byte is valid
//   in_ready  loader accepts a byte this cycle
//   cpu_rst   CPU reset, high until the image is buffered (registered)
//   boot      CPU boot flag
//   wr_en     CPU write enable
//   addr_bus  CPU byte address
//   data_bus  shared data bus, driven only while streaming
//   loaded    boot transfer complete
//   load_err  image rejected
//
// state   | meaning
// --------+------------------------------------------------------------
// LOAD    | receiving image bytes into the buffer
// CHECK   | waiting for the checksum byte (BOOT_CHECKSUM_EN only)
// RELEASE | one-cycle gap after cpu_rst drops
// STREAM  | CPU is booting; buffer words served on data_bus
// DONE    | boot finished, terminal until rst
// ERR     | checksum mismatch, terminal until rst

`ifndef WORD_SIZE
`define WORD_SIZE 16
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif

module boot_loader #(
    parameter int WORD_SIZE = `WORD_SIZE,
    parameter int ADDR_SIZE = `ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic                 cpu_rst,
    input  logic                 boot,
    input  logic                 wr_en,
    input  logic [ADDR_SIZE-1:0] addr_bus,
    inout  wire  [WORD_SIZE-1:0] data_bus,
    output logic                 loaded,
    output logic                 load_err
);

    localparam int PW = ADDR_SIZE - 1;
    localparam int N  = 2 ** PW;

    typedef enum logic [2:0] {
        S_LOAD    = 3'd0,
`ifdef BOOT_CHECKSUM_EN
        S_CHECK   = 3'd1,
`endif
        S_RELEASE = 3'd2,
        S_STREAM  = 3'd3,
        S_DONE    = 3'd4,
        S_ERR     = 3'd5
    } state_t;

    state_t state;
    state_t state_next;

    logic [WORD_SIZE-1:0] buffer [N];
    logic [PW-1:0]        wptr;
    logic                 phase;      // 0: expecting low byte, 1: high byte
    logic [7:0]           hold;
    logic                 xfer;
    logic                 load_xfer;
    logic                 bus_en;
    logic                 unused_addr_lsb;

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum;
`endif

    assign xfer      = in_valid && in_ready;
    assign load_xfer = xfer && (state == S_LOAD);

    // Byte addresses map to words; the low address bit selects nothing.
    assign unused_addr_lsb = addr_bus[0];

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_LOAD;
        else
            state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_LOAD: begin
                // Word N-1 is written by the odd byte while wptr is all ones.
                if (load_xfer && phase && (&wptr)) begin
`ifdef BOOT_CHECKSUM_EN
                    state_next = S_CHECK;
`else
                    state_next = S_RELEASE;
`endif
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CHECK: begin
                if (xfer)
                    state_next = (in_byte == sum) ? S_RELEASE : S_ERR;
            end
`endif
            S_RELEASE: state_next = S_STREAM;
            S_STREAM:  if (!boot) state_next = S_DONE;
            S_DONE:    state_next = S_DONE;
            S_ERR:     state_next = S_ERR;
            default:   state_next = S_LOAD;
        endcase
    end

    // Output logic
    always_comb begin
        in_ready = 1'b0;
        loaded   = 1'b0;
        load_err = 1'b0;
        bus_en   = 1'b0;
        case (state)
            S_LOAD:   in_ready = !rst;
`ifdef BOOT_CHECKSUM_EN
            S_CHECK:  in_ready = !rst;
            S_ERR:    load_err = 1'b1;
`endif
            S_STREAM: bus_en   = boot && wr_en;
            S_DONE:   loaded   = 1'b1;
            default:  ;
        endcase
    end

    // cpu_rst is registered from the next state so it drops on the same
    // edge that enters RELEASE.
    always_ff @(posedge clk) begin
        if (rst)
            cpu_rst <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
        else
            cpu_rst <= (state_next == S_LOAD) || (state_next == S_CHECK) ||
                       (state_next == S_ERR);
`else
        else
            cpu_rst <= (state_next == S_LOAD) || (state_next == S_ERR);
`endif
    end

    // Byte assembly datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            phase <= 1'b0;
            hold  <= 8'h00;
        end else if (load_xfer) begin
            phase <= !phase;
            if (phase)
                wptr <= wptr + 1'b1;
            else
                hold <= in_byte;
        end
    end

`ifdef BOOT_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (rst)
            sum <= 8'h00;
        else if (load_xfer)
            sum <= sum + in_byte;
    end
`endif

    // Image buffer: written only while loading, never reset.
    always_ff @(posedge clk) begin
        if (load_xfer && phase)
            buffer[wptr] <= {in_byte, hold};
    end

    assign data_bus = bus_en ? buffer[addr_bus[ADDR_SIZE-1:1]] : {WORD_SIZE{1'bz}};

endmodule

// File: tb/tb_boot_loader.sv
module tb_boot_loader;

    localparam int WORD_SIZE = 16;
    localparam int ADDR_SIZE = 8;
    localparam int NW        = 128;
    localparam int NB        = 2 * NW;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic        cpu_rst;
    logic        boot;
    logic        wr_en;
    logic [7:0]  addr_bus;
    wire  [15:0] data_bus;
    logic        loaded;
    logic        load_err;
    logic        tb_drive;

    // When the DUT should be high-Z the bench parks the bus at zero, so any
    // stray DUT drive shows up as a nonzero value.
    assign data_bus = tb_drive ? 16'h0000 : 16'hzzzz;

    boot_loader #(.WORD_SIZE(WORD_SIZE), .ADDR_SIZE(ADDR_SIZE)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cpu_rst  (cpu_rst),
        .boot     (boot),
        .wr_en    (wr_en),
        .addr_bus (addr_bus),
        .data_bus (data_bus),
        .loaded   (loaded),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] img [NB];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] img_sum();
        int s = 0;
        for (int i = 0; i < NB; i++) s += img[i];
        return 8'(s % 256);
    endfunction

    function automatic logic [15:0] exp_word(input int byte_addr);
        int w = byte_addr / 2;
        return {img[2 * w + 1], img[2 * w]};
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < NB; i++) img[i] = 8'(i);
    endtask

    task automatic fill_random();
        for (int i = 0; i < NB; i++) img[i] = 8'($urandom_range(0, 255));
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        boot     = 1'b0;
        wr_en    = 1'b1;
        addr_bus = 8'h00;
        tb_drive = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cpu_rst", cpu_rst, 1);
        chk("rst_loaded", loaded, 0);
        chk("rst_load_err", load_err, 0);
        chk("rst_bus_z", data_bus, 0);
        @(posedge clk); #1;
        rst      = 1'b0;
        in_valid = 1'b0;
    endtask

    // vmode: 0 valid always high, 1 toggling, 2 random
    task automatic send_bytes(input int vmode, input int count, input logic [7:0] ck);
        int idx = 0;
        int cyc = 0;
        bit ph  = 1'b1;
        bit fire;
        boot     = 1'b1;
        tb_drive = 1'b1;
        while (idx < count && cyc < 4000) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       begin in_valid = ph; ph = !ph; end
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_byte  = (idx < NB) ? img[idx] : ck;
            wr_en    = 1'($urandom_range(0, 1));
            addr_bus = 8'($urandom_range(0, 255));
            @(negedge clk);
            chk("load_in_ready", in_ready, 1);
            chk("load_cpu_rst", cpu_rst, 1);
            chk("load_bus_z", data_bus, 0);
            chk("load_loaded", loaded, 0);
            fire = in_valid && in_ready;
            @(posedge clk); #1;
            if (fire) idx++;
            cyc++;
        end
        in_valid = 1'b0;
        if (idx < count) chk("send_timeout", idx, count);
    endtask

    // Called right after the final accepted byte; keeps in_valid high to
    // show nothing more is accepted.
    task automatic expect_release();
        in_valid = 1'b1;
        in_byte  = 8'h5A;
        boot     = 1'b1;
        wr_en    = 1'b1;
        addr_bus = 8'h00;
        tb_drive = 1'b1;
        @(negedge clk);
        chk("rel_cpu_rst", cpu_rst, 0);
        chk("rel_in_ready", in_ready, 0);
        chk("rel_bus_z", data_bus, 0);
        chk("rel_load_err", load_err, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic stream_check();
        int a;
        boot = 1'b1;
        for (int i = 0; i < 16; i++) begin
            case (i)
                0:       a = 8'h00;
                1:       a = 8'h01;
                2:       a = 8'hFC;
                3:       a = 8'hFE;
                default: a = $urandom_range(0, 255);
            endcase
            addr_bus = 8'(a);
            wr_en    = 1'b1;
            tb_drive = 1'b0;
            @(negedge clk);
            chk("stream_word", data_bus, exp_word(a));
            chk("stream_cpu_rst", cpu_rst, 0);
            chk("stream_in_ready", in_ready, 0);
            chk("stream_loaded", loaded, 0);
            wr_en    = 1'b0;
            tb_drive = 1'b1;
            #1;
            chk("stream_z_wr0", data_bus, 0);
            @(posedge clk); #1;
        end
        // boot falls: still STREAM this cycle, DONE the next
        boot     = 1'b0;
        wr_en    = 1'b1;
        tb_drive = 1'b1;
        @(negedge clk);
        chk("boot0_loaded", loaded, 0);
        chk("boot0_bus_z", data_bus, 0);
        @(posedge clk); #1;
        boot = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("done_loaded", loaded, 1);
            chk("done_bus_z", data_bus, 0);
            chk("done_cpu_rst", cpu_rst, 0);
            chk("done_in_ready", in_ready, 0);
            chk("done_load_err", load_err, 0);
            @(posedge clk); #1;
        end
    endtask

    task automatic full_image(input int vmode);
`ifdef BOOT_CHECKSUM_EN
        send_bytes(vmode, NB + 1, img_sum());
`else
        send_bytes(vmode, NB, 8'h00);
`endif
        expect_release();
        stream_check();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_byte = 8'h00; boot = 1'b0;
        wr_en = 1'b0; addr_bus = 8'h00; tb_drive = 1'b1;

        // ramp image, valid always high; also pin the known end words
        do_reset();
        fill_ramp();
`ifdef BOOT_CHECKSUM_EN
        chk("ramp_sum_model", img_sum(), 8'h80);
`endif
        full_image(0);
        chk("ramp_word0", exp_word(0), 16'h0100);
        chk("ramp_word127", exp_word(254), 16'hFFFE);

        // same ramp, valid toggling every cycle
        do_reset();
        full_image(1);

        // partial random image, reset, then a different full image
        do_reset();
        fill_random();
        send_bytes(0, 100, 8'h00);
        do_reset();
        fill_random();
        full_image(2);

        // another random image with random valid
        do_reset();
        fill_random();
        full_image(2);

`ifdef BOOT_CHECKSUM_EN
        // bad checksum parks the loader in ERR until reset
        do_reset();
        fill_ramp();
        send_bytes(0, NB + 1, 8'h81);
        in_valid = 1'b1;
        boot     = 1'b1;
        wr_en    = 1'b1;
        tb_drive = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("err_load_err", load_err, 1);
            chk("err_cpu_rst", cpu_rst, 1);
            chk("err_in_ready", in_ready, 0);
            chk("err_loaded", loaded, 0);
            chk("err_bus_z", data_bus, 0);
            @(posedge clk); #1;
        end
        do_reset();
        fill_random();
        full_image(0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
